// File: rtl/qed_pkg.sv
// Shared QED definitions: scheduler state encoding and the control-flow opcodes that end an
// original segment early (also used by qed_decoder).
package qed_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOrig,
    StDup,
    StCheck
  } qed_state_e;

  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;

  function automatic logic is_cf_opcode(input logic [6:0] opcode);
    return (opcode == OpBranch) || (opcode == OpJal) || (opcode == OpJalr) ||
           (opcode == OpSystem) || (opcode == OpMiscMem);
  endfunction

endpackage

// File: rtl/qed_timeout_ctr.sv
// Loadable, clearable saturating up-counter with a terminal-count flag.
module qed_timeout_ctr #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/qed_dup_scheduler.sv
// Alternates the core between original and duplicate instruction phases and pulses qed_check
// when both segment counts match.
module qed_dup_scheduler
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1),
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ifu_vld,
  input  logic             stall_IF,
  input  logic             ifu_is_cf,
  input  logic             qic_vld,
  output logic             exec_dup,
  output logic             qed_check,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             dup_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  qed_state_e       state_q, state_d;
  logic [CNT_W-1:0] orig_q, orig_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic             exec_dup_q, qed_check_q, dup_err_q;
  logic             acc, rep, in_dup, tmo_tc;

  assign acc    = ifu_vld & ~stall_IF;
  assign rep    = acc & qic_vld;
  assign in_dup = (state_q == StDup);

  always_comb begin
    state_d = state_q;
    orig_d  = orig_q;
    dup_d   = dup_q;
    unique case (state_q)
      StIdle: begin
        orig_d = '0;
        dup_d  = '0;
        if (ena) state_d = StOrig;
      end
      StOrig: begin
        if (acc) begin
          orig_d = orig_q + CNT_W'(1);
          // A disable that coincides with an accept still has a non-empty segment to replay.
          if (ifu_is_cf || (orig_q == CNT_W'(DEPTH - 1)) || !ena) state_d = StDup;
        end else if (!ena) begin
          state_d = (orig_q == '0) ? StIdle : StDup;
        end
      end
      StDup: begin
        if (rep) begin
          dup_d = dup_q + CNT_W'(1);
          if (dup_q == orig_q - CNT_W'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        orig_d  = '0;
        dup_d   = '0;
        state_d = ena ? StOrig : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      orig_q      <= '0;
      dup_q       <= '0;
      exec_dup_q  <= 1'b0;
      qed_check_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      orig_q      <= orig_d;
      dup_q       <= dup_d;
      exec_dup_q  <= (state_d == StDup);
      qed_check_q <= (state_d == StCheck);
      dup_err_q   <= dup_err_q | tmo_tc;
    end
  end

  // Counts DUP cycles without a replay; any replay or leaving DUP restarts it.
  qed_timeout_ctr #(
    .WIDTH   (TMO_W),
    .TERMINAL(TIMEOUT - 1)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~in_dup | rep),
    .inc     (in_dup & ~rep),
    .load    (1'b0),
    .load_val({TMO_W{1'b0}}),
    .tc      (tmo_tc)
  );

  assign exec_dup  = exec_dup_q;
  assign qed_check = qed_check_q;
  assign orig_cnt  = orig_q;
  assign dup_cnt   = dup_q;
  assign dup_err   = dup_err_q;

endmodule
